// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM states, opcode/funct constants, reset PC.
// Pure declarations; no timing or flow-control behaviour of its own.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HOLD   = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fields.sv
// Splits a MIPS instruction word into its control and operand fields.
// Purely combinational (zero latency); no flow control.
module instr_fields
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [25:0] jtarget
);

    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign imm     = instr[15:0];
    assign funct   = instr[5:0];
    assign jtarget = instr[25:0];

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch with redirect squash; word valid one cycle after imem_ack.
// Holds the word until id_ready (outputs frozen meanwhile); at most one instruction per two cycles.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [25:0] jtarget,
    output logic        misalign
);

    fetch_state_t state;
    // Next fetch address; while squashing it holds the redirect target, imem_addr the stale one.
    logic [31:0]  pc;
    logic [31:0]  target;
    logic [31:0]  hold_next;

    assign target    = word_align(redirect_pc);
    assign hold_next = redirect_valid ? target : pc;
    assign pc_plus4  = pc_out + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_REQ;
            pc        <= RESET_PC;
            imem_req  <= 1'b1;
            imem_addr <= RESET_PC;
            instr     <= 32'h0;
            pc_out    <= 32'h0;
            if_valid  <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            case (state)
                ST_REQ: begin
                    if (redirect_valid) begin
                        pc <= target;
                        if (imem_ack) begin
                            imem_addr <= target;
                        end else begin
                            state <= ST_SQUASH;
                        end
                    end else if (imem_ack) begin
                        instr    <= imem_rdata;
                        pc_out   <= imem_addr;
                        pc       <= imem_addr + 32'd4;
                        if_valid <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= ST_HOLD;
                    end
                end
                ST_SQUASH: begin
                    if (redirect_valid) begin
                        pc <= target;
                    end
                    if (imem_ack) begin
                        imem_addr <= hold_next;
                        state     <= ST_REQ;
                    end
                end
                ST_HOLD: begin
                    // A redirect alongside id_ready still lets decode consume the word.
                    if (redirect_valid || id_ready) begin
                        pc        <= hold_next;
                        imem_addr <= hold_next;
                        imem_req  <= 1'b1;
                        if_valid  <= 1'b0;
                        state     <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

    instr_fields u_fields (
        .instr   (instr),
        .opcode  (opcode),
        .funct   (funct),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .imm     (imm),
        .jtarget (jtarget)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: fetch addresses and retired words are queued as expected,
// a negedge monitor pops and compares them on every imem handshake and decode handshake.
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic        imem_req, if_valid, misalign;
    logic [31:0] imem_addr, instr, pc_out, pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] jtarget;

    logic        b_imem_req, b_if_valid, b_misalign;
    logic [31:0] b_imem_addr, b_instr, b_pc_out, b_pc_plus4;
    logic [5:0]  b_opcode, b_funct;
    logic [4:0]  b_rs, b_rt, b_rd;
    logic [15:0] b_imm;
    logic [25:0] b_jtarget;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .id_ready(id_ready),
        .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4), .opcode(opcode),
        .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .jtarget(jtarget),
        .misalign(misalign)
    );

    // Second instance sees identical inputs, so it runs in lockstep at a wrapped address base.
    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(b_if_valid), .id_ready(id_ready),
        .instr(b_instr), .pc_out(b_pc_out), .pc_plus4(b_pc_plus4), .opcode(b_opcode),
        .funct(b_funct), .rs(b_rs), .rt(b_rt), .rd(b_rd), .imm(b_imm), .jtarget(b_jtarget),
        .misalign(b_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    exp_t        mon_e;

    int n_vec = 0;
    int n_miss = 0;
    int n_ret = 0;
    int n_mis = 0;
    int ack_lat = 0;
    int acks_left = 0;
    int wait_cnt = 0;
    bit mem_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (mem_mode) return {6'h23, 5'd1, 5'd2, a[15:0]};
        return 32'h0000_0020;
    endfunction

    task automatic push_i(input logic [31:0] w, input logic [31:0] p, input logic [5:0] op,
                          input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                          input logic [15:0] im);
        exp_t e;
        e.instr = w; e.pc = p; e.opcode = op; e.funct = fn; e.rs = s; e.rt = t; e.imm = im;
        exp_q.push_back(e);
    endtask

    task automatic wait_ret(input int target);
        int k = 0;
        while (n_ret < target && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("retired_count", n_ret, target);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!if_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("if_valid_seen", 32'(if_valid), 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    // Memory responder: acks after ack_lat waiting cycles, only while budget remains.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !imem_req || imem_ack || acks_left == 0) begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end else if (wait_cnt >= ack_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = memf(imem_addr);
                acks_left--;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (imem_req && imem_ack) begin
                    if (addr_q.size() == 0) begin
                        n_vec++; n_miss++;
                        $display("FAIL unexpected_fetch: got %h, required no request", imem_addr);
                    end else begin
                        check("imem_addr", imem_addr, addr_q.pop_front());
                    end
                end
                if (if_valid && id_ready) begin
                    n_ret++;
                    if (exp_q.size() == 0) begin
                        n_vec++; n_miss++;
                        $display("FAIL unexpected_instr: got %h, required none", instr);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("instr", instr, mon_e.instr);
                        check("pc_out", pc_out, mon_e.pc);
                        check("pc_plus4", pc_plus4, mon_e.pc + 32'd4);
                        check("opcode", 32'(opcode), 32'(mon_e.opcode));
                        check("funct", 32'(funct), 32'(mon_e.funct));
                        check("rs", 32'(rs), 32'(mon_e.rs));
                        check("rt", 32'(rt), 32'(mon_e.rt));
                        check("rd", 32'(rd), 32'(mon_e.instr[15:11]));
                        check("imm", 32'(imm), 32'(mon_e.imm));
                        check("jtarget", 32'(jtarget), 32'(mon_e.instr[25:0]));
                    end
                end
                if (misalign) n_mis++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst_n          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 32'd1);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_wrap_addr", b_imem_addr, 32'hFFFF_FFFC);

        // Back-to-back fetches with immediate ack and decode always ready
        for (int i = 0; i < 3; i++) begin
            addr_q.push_back(32'(i * 4));
            push_i(32'h0000_0020, 32'(i * 4), 6'h00, 6'h20, 5'd0, 5'd0, 16'h0020);
        end
        acks_left = 3;
        rst_n = 1'b1;
        k = 0;
        while (!b_if_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("wrap_pc_out", b_pc_out, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", b_pc_plus4, 32'h0);
        @(negedge clk);
        check("wrap_next_req", 32'(b_imem_req), 32'd1);
        check("wrap_next_addr", b_imem_addr, 32'h0);
        wait_ret(3);

        // Decode stalls for five cycles: held word must stay frozen
        id_ready = 1'b0;
        mem_mode = 1'b1;
        addr_q.push_back(32'h0000_000C);
        push_i(32'h8C22_000C, 32'h0000_000C, 6'h23, 6'h0C, 5'd1, 5'd2, 16'h000C);
        acks_left = 1;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_if_valid", 32'(if_valid), 32'd1);
            check("stall_instr", instr, 32'h8C22_000C);
            check("stall_pc_out", pc_out, 32'h0000_000C);
        end
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        @(posedge clk);
        #1;
        id_ready = 1'b0;
        wait_ret(4);

        // Redirect while holding drops the held word
        addr_q.push_back(32'h0000_0010);
        acks_left = 1;
        wait_valid();
        pulse_redirect(32'h0000_0100);
        @(negedge clk);
        check("hold_redir_if_valid", 32'(if_valid), 32'd0);
        check("hold_redir_addr", imem_addr, 32'h0000_0100);
        addr_q.push_back(32'h0000_0100);
        push_i(32'h8C22_0100, 32'h0000_0100, 6'h23, 6'h00, 5'd1, 5'd2, 16'h0100);
        acks_left = 1;
        id_ready  = 1'b1;
        wait_ret(5);

        // Redirect while request pending, then a second redirect during squash; last one wins
        ack_lat        = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0180;
        @(posedge clk);
        #1;
        redirect_pc = 32'h0000_0200;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("squash_stale_addr", imem_addr, 32'h0000_0104);
        check("squash_req", 32'(imem_req), 32'd1);
        check("squash_if_valid", 32'(if_valid), 32'd0);
        addr_q.push_back(32'h0000_0104);
        addr_q.push_back(32'h0000_0200);
        push_i(32'h8C22_0200, 32'h0000_0200, 6'h23, 6'h00, 5'd1, 5'd2, 16'h0200);
        acks_left = 2;
        wait_ret(6);

        // Misaligned redirect: forced to word boundary, misalign pulses exactly once
        ack_lat  = 0;
        id_ready = 1'b0;
        addr_q.push_back(32'h0000_0204);
        acks_left = 1;
        wait_valid();
        pulse_redirect(32'h0000_0203);
        @(negedge clk);
        check("misalign_pulse", 32'(misalign), 32'd1);
        check("misalign_addr", imem_addr, 32'h0000_0200);
        check("misalign_if_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        check("misalign_clear", 32'(misalign), 32'd0);
        addr_q.push_back(32'h0000_0200);
        push_i(32'h8C22_0200, 32'h0000_0200, 6'h23, 6'h00, 5'd1, 5'd2, 16'h0200);
        acks_left = 1;
        id_ready  = 1'b1;
        wait_ret(7);

        // Redirect in the same cycle as imem_ack: returned word discarded
        addr_q.push_back(32'h0000_0204);
        addr_q.push_back(32'h0000_0300);
        push_i(32'h8C22_0300, 32'h0000_0300, 6'h23, 6'h00, 5'd1, 5'd2, 16'h0300);
        acks_left = 1;
        k = 0;
        while (imem_ack !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ack_redir_seen", 32'(imem_ack), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("ack_redir_if_valid", 32'(if_valid), 32'd0);
        check("ack_redir_addr", imem_addr, 32'h0000_0300);
        acks_left = 1;
        wait_ret(8);

        check("addr_queue_drained", 32'(addr_q.size()), 32'd0);
        check("instr_queue_drained", 32'(exp_q.size()), 32'd0);
        check("misalign_pulse_count", n_mis, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the word-aligned PC loaded on reset.
REQ-002 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL indicate a read request to instruction memory.
REQ-005 imem_addr  output  32  SHALL be the byte address of the requested word.
REQ-006 imem_ack  input  1  SHALL mark imem_rdata valid for the outstanding request.
REQ-007 imem_rdata  input  32  SHALL be the instruction word returned by memory.
REQ-008 redirect_valid  input  1  SHALL request a PC change from a taken branch, j, jal or jr.
REQ-009 redirect_pc  input  32  SHALL be the redirect target address.
REQ-010 if_valid  output  1  SHALL indicate a held instruction is presented to decode.
REQ-011 id_ready  input  1  SHALL indicate decode accepts the held instruction this cycle.
REQ-012 instr, pc_out, pc_plus4  output  32 each  SHALL be the held word, its address, and address+4.
REQ-013 opcode, funct  output  6 each  SHALL be instr[31:26] and instr[5:0], feeding the control unit.
REQ-014 rs, rt, rd  output  5 each  SHALL be instr[25:21], instr[20:16], instr[15:11].
REQ-015 imm  output  16  SHALL be instr[15:0]; jtarget  output  26  SHALL be instr[25:0].
REQ-016 misalign  output  1  SHALL pulse for one cycle when redirect_pc[1:0] is nonzero.

Function
REQ-017 States SHALL be REQ (request outstanding), SQUASH (stale request outstanding) and HOLD (instruction held).
REQ-018 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal the PC, held stable until imem_ack.
REQ-019 In REQ, on imem_ack without redirect: capture imem_rdata and the PC, PC <= PC+4, go to HOLD.
REQ-020 In HOLD, if_valid SHALL be 1; on id_ready without redirect, go to REQ the next cycle.
REQ-021 Fetch-to-if_valid latency SHALL be one cycle after imem_ack; throughput SHALL be at most one instruction per two cycles.
REQ-022 Redirect in HOLD SHALL drop the held instruction (if_valid 0 next cycle), load PC from redirect_pc, and go to REQ.
REQ-023 Redirect in REQ with imem_ack in the same cycle SHALL discard imem_rdata, load the new PC, and go to REQ.
REQ-024 Redirect in REQ without imem_ack SHALL load the new PC and go to SQUASH; imem_addr SHALL keep the old address.
REQ-025 In SQUASH, imem_req SHALL stay 1; on imem_ack the data SHALL be discarded and the state SHALL go to REQ.
REQ-026 A further redirect in SQUASH SHALL overwrite the pending PC; the last redirect wins.
REQ-027 Redirect and id_ready in the same HOLD cycle SHALL complete the handshake (instruction consumed) and also apply the redirect.
REQ-028 Redirect addresses SHALL have bits [1:0] forced to 0; misalign SHALL assert when the raw bits are nonzero.
REQ-029 PC+4 arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-030 Outputs SHALL be stable while if_valid=1 and id_ready=0.

Reset
REQ-031 While rst_n=0 at a clock edge: state <= REQ, PC <= RESET_PC, instr <= 32'h0 (nop), if_valid <= 0, misalign <= 0.
REQ-032 Reset mid-request SHALL abandon any outstanding request without squash; the first imem_ack after reset SHALL be accepted.

Structure
REQ-033 Shared package mips_pkg SHALL hold the state enum, opcode constants and the RESET_PC default.
REQ-034 Field extraction SHALL be one combinational sub-module, instr_fields, reused by decode.

Verification
REQ-035 Reset, then ack every request with rdata=32'h0000_0020 and id_ready=1: imem_addr sequence 0,4,8; opcode 0; funct 6'h20.
REQ-036 Hold id_ready=0 for 5 cycles in HOLD: if_valid=1, and instr/pc_out remain unchanged throughout.
REQ-037 Redirect to 32'h100 in HOLD: held word dropped; next imem_addr is 32'h100.
REQ-038 Redirect to 32'h200 in REQ with ack delayed 3 cycles: stale data is discarded (SQUASH); the next request is at 32'h200.
REQ-039 Redirect to 32'h203: misalign pulses once; fetch address is 32'h200.
REQ-040 RESET_PC=32'hFFFF_FFFC, one fetch: pc_plus4=0 and the next imem_addr is 0.
